// File: rtl/sr04_scheduler.sv
// Arbitrates auto/button/UART measurement requests for an SR04 sensor controller.
// Optional build macro SR04_AVG_EN: dist_out becomes a 4-sample running average.
module sr04_scheduler #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int PERIOD_MS  = 100,
   parameter int TIMEOUT_MS = 30,
   parameter int HOLDOFF_MS = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       auto_en,
   input  logic       req_uart,
   input  logic       req_btn,
   input  logic [9:0] sr04_distance,
   input  logic       sr04_done,
   output logic       sr04_start,
   output logic [9:0] dist_out,
   output logic       dist_valid,
   output logic       err_timeout,
   output logic [1:0] owner,
   output logic       busy
);

   localparam int TICK_DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
   localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, START, WAIT, HOLDOFF} state_t;

   state_t          state_reg;
   logic [PW-1:0]   pre_reg;
   logic            ms_tick;
   logic [9:0]      per_reg;
   logic [7:0]      tmo_reg;
   logic [7:0]      hold_reg;
   logic            uart_pend_reg;
   logic            btn_pend_reg;
   logic            auto_pend_reg;
   logic            auto_set;
   logic            grant_uart;
   logic            grant_btn;
   logic            grant_auto;
   logic            capture;

   assign ms_tick    = (pre_reg == PW'(TICK_DIV - 1));
   assign auto_set   = ms_tick && (per_reg == 10'(PERIOD_MS - 1));
   assign grant_uart = (state_reg == IDLE) && uart_pend_reg;
   assign grant_btn  = (state_reg == IDLE) && !uart_pend_reg && btn_pend_reg;
   assign grant_auto = (state_reg == IDLE) && !uart_pend_reg && !btn_pend_reg && auto_pend_reg;
   assign capture    = (state_reg == WAIT) && sr04_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_reg <= '0;
      end else if (ms_tick) begin
         pre_reg <= '0;
      end else begin
         pre_reg <= pre_reg + 1'b1;
      end
   end

   // A new request in the same cycle as its grant survives the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per_reg       <= '0;
         uart_pend_reg <= 1'b0;
         btn_pend_reg  <= 1'b0;
         auto_pend_reg <= 1'b0;
      end else begin
         uart_pend_reg <= (uart_pend_reg && !grant_uart) || req_uart;
         btn_pend_reg  <= (btn_pend_reg && !grant_btn) || req_btn;
         if (!auto_en) begin
            per_reg       <= '0;
            auto_pend_reg <= 1'b0;
         end else begin
            auto_pend_reg <= (auto_pend_reg && !grant_auto) || auto_set;
            if (ms_tick) begin
               per_reg <= auto_set ? 10'd0 : per_reg + 10'd1;
            end
         end
      end
   end

   // Holdoff is measured in whole ms ticks from START, so the restart
   // spacing is quantised to the free-running tick phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         tmo_reg     <= '0;
         hold_reg    <= '0;
         sr04_start  <= 1'b0;
         dist_valid  <= 1'b0;
         err_timeout <= 1'b0;
         owner       <= 2'd0;
         busy        <= 1'b0;
      end else begin
         sr04_start  <= 1'b0;
         dist_valid  <= 1'b0;
         err_timeout <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (uart_pend_reg || btn_pend_reg || auto_pend_reg) begin
                  state_reg  <= START;
                  sr04_start <= 1'b1;
                  busy       <= 1'b1;
                  owner      <= grant_uart ? 2'd2 : (grant_btn ? 2'd1 : 2'd0);
               end
            end
            START: begin
               tmo_reg   <= '0;
               hold_reg  <= '0;
               state_reg <= WAIT;
            end
            WAIT: begin
               if (ms_tick) begin
                  tmo_reg <= tmo_reg + 8'd1;
                  if (hold_reg != 8'hFF) hold_reg <= hold_reg + 8'd1;
               end
               if (sr04_done) begin
                  dist_valid <= 1'b1;
                  state_reg  <= HOLDOFF;
               end else if (tmo_reg == 8'(TIMEOUT_MS)) begin
                  err_timeout <= 1'b1;
                  state_reg   <= HOLDOFF;
               end
            end
            HOLDOFF: begin
               if (hold_reg >= 8'(HOLDOFF_MS)) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
               end else if (ms_tick && hold_reg != 8'hFF) begin
                  hold_reg <= hold_reg + 8'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef SR04_AVG_EN
   logic [9:0]  hist_reg [0:2];
   logic [1:0]  n_reg;
   logic [11:0] sum4;

   assign sum4 = 12'(hist_reg[0]) + 12'(hist_reg[1]) + 12'(hist_reg[2]) + 12'(sr04_distance);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_reg[0] <= '0;
         n_reg       <= '0;
         dist_out    <= '0;
      end else if (capture) begin
         hist_reg[0] <= sr04_distance;
         if (n_reg != 2'd3) n_reg <= n_reg + 2'd1;
         // Three older samples plus the new one make a full window.
         dist_out <= (n_reg == 2'd3) ? sum4[11:2] : sr04_distance;
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi < 3; gi++) begin : g_hist
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               hist_reg[gi] <= '0;
            end else if (capture) begin
               hist_reg[gi] <= hist_reg[gi-1];
            end
         end
      end
   endgenerate
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dist_out <= '0;
      end else if (capture) begin
         dist_out <= sr04_distance;
      end
   end
`endif

endmodule

// File: doc/sr04_scheduler.md
SR04_SCHEDULER -- requirements
Module: sr04_scheduler

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: clk frequency in Hz, used to derive the internal 1 ms tick.
REQ-002 Parameter PERIOD_MS, default 100: auto-mode measurement period in ms, valid range 1..1023.
REQ-003 Parameter TIMEOUT_MS, default 30: maximum wait for dist_done after sr04_start, valid range 1..255.
REQ-004 Parameter HOLDOFF_MS, default 60: minimum time from one sr04_start to the next, valid range 1..255.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 auto_en  input  1  level; enables periodic measurements.
REQ-008 req_uart  input  1  single-cycle single-shot request from the UART command path.
REQ-009 req_btn  input  1  single-cycle single-shot request from the debounced button.
REQ-010 sr04_distance  input  10  distance in cm from the sensor controller.
REQ-011 sr04_done  input  1  single-cycle completion pulse from the sensor controller.
REQ-012 sr04_start  output  1  single-cycle start pulse to the sensor controller.
REQ-013 dist_out  output  10  last reported distance in cm.
REQ-014 dist_valid  output  1  single-cycle pulse; dist_out is updated.
REQ-015 err_timeout  output  1  single-cycle pulse; the measurement timed out.
REQ-016 owner  output  2  requester of the current/last result: 0 = auto, 1 = btn, 2 = uart.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 Internal ms_tick pulses once every CLK_HZ/1000 clk cycles; all ms counters advance only on ms_tick.
REQ-019 Each requester has a one-deep pending flag: set by its request pulse, cleared when that requester is granted; repeated requests while the flag is set merge into one.
REQ-020 Auto pending is set when the period counter reaches PERIOD_MS-1 while auto_en=1; the counter then wraps to 0.
REQ-021 auto_en=0 holds the period counter at 0 and clears auto pending in the same cycle.
REQ-022 Grant priority is fixed: uart > btn > auto; when several flags are pending, the lower-priority flags stay pending.
REQ-023 FSM states are IDLE, START, WAIT, HOLDOFF.
REQ-024 IDLE -> START when any flag is pending; owner latches the granted requester in the same cycle.
REQ-025 START: sr04_start=1 for exactly one cycle, the timeout and holdoff counters clear, then -> WAIT.
REQ-026 WAIT: when sr04_done=1, capture sr04_distance, pulse dist_valid the next cycle (latency 1 clk), then -> HOLDOFF.
REQ-027 WAIT: if the timeout counter reaches TIMEOUT_MS with no sr04_done, pulse err_timeout, leave dist_out unchanged, then -> HOLDOFF.
REQ-028 If sr04_done and the timeout occur in the same cycle, sr04_done wins and err_timeout is not pulsed.
REQ-029 HOLDOFF: the holdoff counter keeps counting from START; -> IDLE when it reaches HOLDOFF_MS; requests arriving meanwhile are latched.
REQ-030 sr04_done outside WAIT is ignored.
REQ-031 A request arriving in the same cycle its flag is cleared by a grant is kept pending.

Reset
REQ-032 While rst=1: FSM=IDLE; all counters, pending flags, and averaging state are 0; sr04_start=0, dist_out=0, dist_valid=0, err_timeout=0, owner=0, busy=0.
REQ-033 rst asserted mid-measurement aborts it with no dist_valid or err_timeout pulse; a sr04_done arriving after rst is released while in IDLE is ignored.

Configuration
REQ-034 Macro SR04_AVG_EN defined: dist_out is the running average of the last 4 valid samples, (sum of 4) >> 2, computed with a 12-bit sum.
REQ-035 With SR04_AVG_EN, until 4 valid samples have been collected since reset, dist_out equals the raw sample; timed-out measurements are not entered into the average.
REQ-036 SR04_AVG_EN undefined: dist_out is the raw captured sample; no averaging logic is synthesized.

Verification
REQ-037 auto_en=1, sensor model returns 200 after 12 ms each time -> sr04_start every 100 ms, dist_out=200, owner=0, one dist_valid per period.
REQ-038 req_btn and req_uart in the same cycle while IDLE -> uart is served first (owner=2); btn is served after the 60 ms holdoff (owner=1).
REQ-039 Sensor never answers -> err_timeout pulse 30 ms after sr04_start; dist_out holds its previous value; next sr04_start no earlier than 60 ms after the previous one.
REQ-040 SR04_AVG_EN defined, samples 100, 104, 108, 112, 116 -> dist_out sequence 100, 104, 108, 106, 110.
REQ-041 rst pulsed during WAIT, then sr04_done -> no dist_valid pulse, all outputs 0, FSM=IDLE.
REQ-042 Three req_btn pulses during HOLDOFF -> exactly one additional measurement is run.
